// File: rtl/cache_refill_engine.sv
// ---------------------------------------------------------------------------
// cache_refill_engine
//
// Miss-handling stage that sits behind the 4-way set-associative cache
// controller. A miss request carries the missing address plus the state of
// the victim way picked by the controller. A dirty victim is first written
// back to memory one bus word at a time. The missing line is then fetched one
// word at a time, and a single fill pulse hands the whole line back to the
// controller for installation.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    miss request handshake (ready == engine idle)
//   req_addr           missing byte address (offset bits ignored)
//   req_dirty          victim line is valid and dirty
//   req_victim_tag     tag of the victim line
//   req_victim_data    victim line, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   mem_req_*          word-wide memory request channel (we=1 write)
//   mem_rvalid/rdata   read return channel, in order, one read outstanding
//   fill_valid         one-cycle pulse: fill_tag/index/line are ready
//   fill_tag/index     identity of the filled line
//   fill_line          filled line, same word layout as req_victim_data
//   dbg_state          current FSM state (IDLE=0 WB=1 RD_REQ=2 RD_WAIT=3 FILL=4)
//
// Handshake rules: a transfer on either request channel happens on a rising
// edge where valid && ready are both high. While valid is high and ready is
// low, the payload (address, write enable, write data) is held unchanged, and
// valid is never withdrawn before the transfer completes. mem_rvalid has no
// back-pressure and is only honoured while a read is outstanding.
// ---------------------------------------------------------------------------
module cache_refill_engine #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int TAG_BITS        = 18,
  parameter int INDEX_BITS      = 8,
  parameter int OFFSET_BITS     = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDRESS_WIDTH-1:0]        req_addr,
  input  logic                            req_dirty,
  input  logic [TAG_BITS-1:0]             req_victim_tag,
  input  logic [LINE_SIZE_BYTES*8-1:0]    req_victim_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic                            mem_req_we,
  output logic [ADDRESS_WIDTH-1:0]        mem_req_addr,
  output logic [DATA_WIDTH-1:0]           mem_req_wdata,
  input  logic                            mem_rvalid,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            fill_valid,
  output logic [TAG_BITS-1:0]             fill_tag,
  output logic [INDEX_BITS-1:0]           fill_index,
  output logic [LINE_SIZE_BYTES*8-1:0]    fill_line,
  output logic [2:0]                      dbg_state
);

  localparam int LINE_BITS  = LINE_SIZE_BYTES * 8;
  localparam int WORDS      = LINE_BITS / DATA_WIDTH;
  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FILL    = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [TAG_BITS-1:0]      r_tag;
  logic [INDEX_BITS-1:0]    r_index;
  logic [TAG_BITS-1:0]      r_vtag;
  logic [LINE_BITS-1:0]     r_vdata;
  logic [LINE_BITS-1:0]     r_fill_line;

  logic                     w_last;
  logic [ADDRESS_WIDTH-1:0] w_wb_base;
  logic [ADDRESS_WIDTH-1:0] w_rd_base;
  logic [ADDRESS_WIDTH-1:0] w_cnt_off;
  logic                     w_unused_offset;

  assign w_last    = (r_cnt == LAST_WORD);
  // Line bases are line-aligned, so adding the word offset never carries
  // into the index field.
  assign w_wb_base = {r_vtag, r_index, {OFFSET_BITS{1'b0}}};
  assign w_rd_base = {r_tag,  r_index, {OFFSET_BITS{1'b0}}};
  assign w_cnt_off = ADDRESS_WIDTH'(r_cnt) * ADDRESS_WIDTH'(WORD_BYTES);

  // Byte offset of the missing address does not matter: whole lines move.
  assign w_unused_offset = ^req_addr[OFFSET_BITS-1:0];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (req_valid)     w_state_nxt = req_dirty ? S_WB : S_RD_REQ;
      S_WB:      if (mem_req_ready && w_last) w_state_nxt = S_RD_REQ;
      S_RD_REQ:  if (mem_req_ready) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid)    w_state_nxt = w_last ? S_FILL : S_RD_REQ;
      S_FILL:                       w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs, decoded only from registered state, counter and latched
  // request data so they stay stable across a stalled handshake.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    fill_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = w_wb_base + w_cnt_off;
        mem_req_wdata = r_vdata[r_cnt*DATA_WIDTH +: DATA_WIDTH];
      end
      S_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = w_rd_base + w_cnt_off;
      end
      S_FILL: begin
        fill_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: request latch, word counter, fill line assembly
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_tag       <= '0;
      r_index     <= '0;
      r_vtag      <= '0;
      r_vdata     <= '0;
      r_fill_line <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cnt   <= '0;
            r_tag   <= req_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
            r_index <= req_addr[OFFSET_BITS +: INDEX_BITS];
            r_vtag  <= req_victim_tag;
            r_vdata <= req_victim_data;
          end
        end
        S_WB: begin
          // The counter restarts at zero for the read phase after the last
          // writeback word.
          if (mem_req_ready) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          end
        end
        S_RD_WAIT: begin
          // Read data is only captured here; returns seen in any other state
          // cannot belong to an outstanding read.
          if (mem_rvalid) begin
            r_fill_line[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            if (!w_last) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fill_tag   = r_tag;
  assign fill_index = r_index;
  assign fill_line  = r_fill_line;
  assign dbg_state  = r_state;

endmodule
